// File: rtl/rx_381bit_pkg.sv
// ---------------------------------------------------------------------------
// rx_381bit_pkg: shared frame constants, state encodings and pad check helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rx_381bit_pkg;

  localparam int FRAME_BYTES = 48;
  localparam int PAD_BITS    = 2;
  localparam int DATA_BITS   = 382;
  localparam int FRAME_BITS  = FRAME_BYTES * 8;
  localparam int COUNT_W     = $clog2(FRAME_BYTES + 1);

  // Assembler encoding matches the transmitter's byte-count sequencing.
  typedef enum logic [1:0] {
    ASM_IDLE    = 2'd0,
    ASM_COLLECT = 2'd1,
    ASM_CHECK   = 2'd2
  } asm_state_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  function automatic logic pad_ok(input logic [FRAME_BITS-1:0] frame);
    return frame[FRAME_BITS-1 -: PAD_BITS] == '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_381bit_if.sv
// ---------------------------------------------------------------------------
// rx_381bit_if: UART line input and frame result outputs of rx_381bit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rx_381bit_if;
  import rx_381bit_pkg::*;

  logic                 RxD;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 done;
  logic                 err;

  modport master (output RxD, input data, valid, done, err);
  modport slave  (input RxD, output data, valid, done, err);

endinterface

`default_nettype wire

// File: rtl/rx_381bit_uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte: 8N1 bit-level receiver with glitch rejection and framing error
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_byte
  import rx_381bit_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic       o_wr,
  output logic [7:0] o_data,
  output logic       o_ferr,
  output logic       o_busy
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CNT_W-1:0] c_baud_last = CNT_W'(CLOCKS_PER_BAUD - 1);
  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLOCKS_PER_BAUD / 2 - 1);

  logic             r_meta, r_sync, r_prev;
  rx_state_t        r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [2:0]       r_bit, w_bit;
  logic [7:0]       r_shift, w_shift;
  logic [7:0]       r_data, w_data;
  logic             r_wr, w_wr;
  logic             r_ferr, w_ferr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta  <= 1'b1;
      r_sync  <= 1'b1;
      r_prev  <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_wr    <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_meta  <= i_rx;
      r_sync  <= r_meta;
      r_prev  <= r_sync;
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_data  <= w_data;
      r_wr    <= w_wr;
      r_ferr  <= w_ferr;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_data  = r_data;
    w_wr    = 1'b0;
    w_ferr  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (r_prev && !r_sync) begin
          w_state = RX_START;
          w_cnt   = '0;
        end
      end
      RX_START: begin
        if (r_cnt == c_half_last) begin
          w_cnt   = '0;
          w_bit   = '0;
          // Line back high at mid start bit means the edge was a glitch.
          w_state = r_sync ? RX_IDLE : RX_DATA;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (r_cnt == c_baud_last) begin
          w_cnt   = '0;
          w_shift = {r_sync, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state = RX_STOP;
          end else begin
            w_bit = r_bit + 1'b1;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_cnt == c_baud_last) begin
          w_cnt = '0;
          if (r_sync) begin
            w_wr    = 1'b1;
            w_data  = r_shift;
            w_state = RX_IDLE;
          end else begin
            w_ferr  = 1'b1;
            w_state = RX_WAIT_HIGH;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (r_sync) begin
          w_state = RX_IDLE;
        end
      end
      default: begin
        w_state = RX_IDLE;
      end
    endcase
  end

  assign o_wr   = r_wr;
  assign o_data = r_data;
  assign o_ferr = r_ferr;
  assign o_busy = (r_state != RX_IDLE);

endmodule

`default_nettype wire

// File: rtl/rx_381bit.sv
// ---------------------------------------------------------------------------
// rx_381bit: assembles 48 UART bytes (MSB byte first) into a checked 382-bit frame
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rx_381bit
  import rx_381bit_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = 868,
  parameter int TIMEOUT_BAUDS   = 32
) (
  input  logic        clk,
  input  logic        reset,
  rx_381bit_if.slave  bus
);

  localparam int c_timeout = TIMEOUT_BAUDS * CLOCKS_PER_BAUD;
  localparam int TMR_W     = $clog2(c_timeout + 1);
  localparam logic [TMR_W-1:0]   c_tmr_last   = TMR_W'(c_timeout - 1);
  localparam logic [COUNT_W-1:0] c_count_last = COUNT_W'(FRAME_BYTES - 1);

  logic       w_byte_wr, w_byte_ferr, w_byte_busy;
  logic [7:0] w_byte_data;

  uart_rx_byte #(
    .CLOCKS_PER_BAUD (CLOCKS_PER_BAUD)
  ) u_rx (
    .clk    (clk),
    .reset  (reset),
    .i_rx   (bus.RxD),
    .o_wr   (w_byte_wr),
    .o_data (w_byte_data),
    .o_ferr (w_byte_ferr),
    .o_busy (w_byte_busy)
  );

  asm_state_t           r_state, w_state;
  logic [FRAME_BITS-1:0] r_sr, w_sr;
  logic [COUNT_W-1:0]   r_count, w_count;
  logic [TMR_W-1:0]     r_timer, w_timer;
  logic [DATA_BITS-1:0] r_data, w_data;
  logic                 r_valid, w_valid;
  logic                 r_done, w_done;
  logic                 r_err, w_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ASM_IDLE;
      r_sr    <= '0;
      r_count <= '0;
      r_timer <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sr    <= w_sr;
      r_count <= w_count;
      r_timer <= w_timer;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  always_comb begin
    w_state = r_state;
    w_sr    = r_sr;
    w_count = r_count;
    w_timer = r_timer;
    w_data  = r_data;
    w_valid = 1'b0;
    w_done  = r_done;
    w_err   = r_err;
    case (r_state)
      ASM_IDLE: begin
        w_timer = '0;
        if (w_byte_wr) begin
          w_sr    = {r_sr[FRAME_BITS-9:0], w_byte_data};
          w_count = COUNT_W'(1);
          w_err   = 1'b0;
          w_state = ASM_COLLECT;
        end
      end
      ASM_COLLECT: begin
        if (w_byte_wr) begin
          w_sr    = {r_sr[FRAME_BITS-9:0], w_byte_data};
          w_count = r_count + 1'b1;
          w_timer = '0;
          if (r_count == c_count_last) begin
            w_state = ASM_CHECK;
          end
        end else if (w_byte_ferr) begin
          w_err   = 1'b1;
          w_count = '0;
          w_timer = '0;
          w_state = ASM_IDLE;
        end else if (!w_byte_busy) begin
          // Only line-idle time between bytes counts toward the timeout.
          if (r_timer == c_tmr_last) begin
            w_err   = 1'b1;
            w_count = '0;
            w_timer = '0;
            w_state = ASM_IDLE;
          end else begin
            w_timer = r_timer + 1'b1;
          end
        end
      end
      ASM_CHECK: begin
        if (pad_ok(r_sr)) begin
          w_data  = r_sr[DATA_BITS-1:0];
          w_valid = 1'b1;
          w_done  = 1'b1;
        end else begin
          w_err = 1'b1;
        end
        w_count = '0;
        w_state = ASM_IDLE;
      end
      default: begin
        w_state = ASM_IDLE;
      end
    endcase
  end

  assign bus.data  = r_data;
  assign bus.valid = r_valid;
  assign bus.done  = r_done;
  assign bus.err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rx_381bit.sv
// ---------------------------------------------------------------------------
// tb_rx_381bit: directed and randomized frame reception against a byte-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rx_381bit;
  import rx_381bit_pkg::*;

  localparam int CPB = 16;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rx_381bit_if bus ();

  rx_381bit #(
    .CLOCKS_PER_BAUD (CPB),
    .TIMEOUT_BAUDS   (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_wr = 0, n_ferr = 0, n_valid = 0, last_wr_cyc = -100, last_lat = 0;
  always @(negedge clk) begin
    if (dut.u_rx.o_wr) begin
      n_wr        <= n_wr + 1;
      last_wr_cyc <= cyc;
    end
    if (dut.u_rx.o_ferr) n_ferr <= n_ferr + 1;
    if (bus.valid) begin
      n_valid  <= n_valid + 1;
      last_lat <= cyc - last_wr_cyc;
    end
  end

  // Reference model state.
  logic [7:0]           fb [FRAME_BYTES];
  logic [DATA_BITS-1:0] exp_data = '0;
  int                   exp_done = 0, exp_err = 0, exp_valid = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [DATA_BITS-1:0] obs,
                          input logic [DATA_BITS-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.RxD = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.RxD = b[i];
      tick(CPB);
    end
    bus.RxD = stop;
    tick(CPB);
    bus.RxD = 1'b1;
  endtask

  task automatic send_bytes(input int from, input int to);
    for (int i = from; i < to; i++) send_byte(fb[i], 1'b1);
  endtask

  task automatic fill_random(input bit good);
    for (int i = 0; i < FRAME_BYTES; i++) fb[i] = 8'($urandom);
    if (good) fb[0][7:6] = 2'b00;
    else      fb[0][7:6] = 2'($urandom_range(1, 3));
  endtask

  // Frame = bytes laid out MSB byte first; accept only if the pad bits are zero.
  task automatic expect_frame(output bit good);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    for (int i = 0; i < FRAME_BYTES; i++) f[FRAME_BITS-1-8*i -: 8] = fb[i];
    good = (f[FRAME_BITS-1 -: PAD_BITS] == 2'b00);
    if (good) begin
      exp_data = f[DATA_BITS-1:0];
      exp_valid++;
      exp_done = 1;
      exp_err  = 0;
    end else begin
      exp_err = 1;
    end
  endtask

  task automatic check_all(input string tag, input bit good);
    chk_data({tag, "_data"}, bus.data, exp_data);
    chk({tag, "_nvalid"}, n_valid, exp_valid);
    chk({tag, "_done"}, 32'(bus.done), exp_done);
    chk({tag, "_err"}, 32'(bus.err), exp_err);
    if (good) chk({tag, "_latency"}, last_lat, 2);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit good;
    int w0, f0;
    bus.RxD = 1'b1;
    tick(4);
    chk_data("rst_data", bus.data, '0);
    chk("rst_valid", 32'(bus.valid), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    reset = 1'b1;
    tick(5);

    // Incrementing bytes 0x00..0x2F.
    for (int i = 0; i < FRAME_BYTES; i++) fb[i] = 8'(i);
    send_bytes(0, FRAME_BYTES);
    expect_frame(good);
    tick(20);
    check_all("incr", good);

    // Non-zero pad bits.
    fb[0] = 8'hC1;
    for (int i = 1; i < FRAME_BYTES; i++) fb[i] = 8'hFF;
    send_bytes(0, FRAME_BYTES);
    expect_frame(good);
    tick(20);
    check_all("badpad", good);

    // Good frame after error: err clears on its first byte.
    fill_random(1'b1);
    send_bytes(0, 1);
    chk("err_clear_first_byte", 32'(bus.err), 0);
    send_bytes(1, FRAME_BYTES);
    expect_frame(good);
    tick(20);
    check_all("recover", good);

    // Partial frame then idle line past the timeout.
    fill_random(1'b1);
    send_bytes(0, 20);
    tick(100);
    exp_err = 1;
    check_all("timeout", 1'b0);
    fill_random(1'b1);
    send_bytes(0, FRAME_BYTES);
    expect_frame(good);
    tick(20);
    check_all("after_tmo", good);

    // Framing error on the tenth byte.
    fill_random(1'b1);
    send_bytes(0, 9);
    f0 = n_ferr;
    send_byte(fb[9], 1'b0);
    tick(20);
    chk("ferr_pulse", n_ferr - f0, 1);
    exp_err = 1;
    check_all("ferr", 1'b0);
    fill_random(1'b1);
    send_bytes(0, FRAME_BYTES);
    expect_frame(good);
    tick(20);
    check_all("after_ferr", good);

    // One-cycle glitch on an idle line.
    w0 = n_wr;
    bus.RxD = 1'b0;
    tick(1);
    bus.RxD = 1'b1;
    tick(40);
    chk("glitch_no_wr", n_wr - w0, 0);
    chk("glitch_idle", 32'(dut.r_state), 32'(ASM_IDLE));
    check_all("glitch", 1'b0);

    // Reset mid-frame.
    fill_random(1'b1);
    send_bytes(0, 30);
    reset = 1'b0;
    #1;
    exp_data = '0;
    exp_done = 0;
    exp_err  = 0;
    chk_data("midrst_data", bus.data, exp_data);
    chk("midrst_done", 32'(bus.done), 0);
    tick(3);
    chk("midrst_valid", 32'(bus.valid), 0);
    chk("midrst_err", 32'(bus.err), 0);
    reset = 1'b1;
    tick(5);
    fill_random(1'b1);
    send_bytes(0, FRAME_BYTES);
    expect_frame(good);
    tick(20);
    check_all("post_rst", good);

    // Random good/bad frames.
    for (int k = 0; k < 2; k++) begin
      fill_random(1'($urandom_range(0, 1)));
      send_bytes(0, FRAME_BYTES);
      expect_frame(good);
      tick(20);
      check_all("rand", good);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rx_381bit.md
# rx_381bit

Receive-side counterpart of the 381-bit UART transmitter. It deserialises 8N1 UART bytes on `RxD` and assembles 48 consecutive bytes, MSB byte first, into a 384-bit frame. The two top pad bits must be zero; the remaining 382 bits are published on `data`. It sits between the board UART pin and the 381-bit adder input registers, and returns a `done` handshake to the control FSM.

## Interface
- `CLOCKS_PER_BAUD`, 868, clock cycles per UART bit (100 MHz / 115200); must be ≥ 8.
- `TIMEOUT_BAUDS`, 32, idle bit-times allowed between bytes inside a frame before the partial frame is discarded.
- `clk` input 1: single clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `RxD` input 1: asynchronous UART line; idle high.
- `data` output 382: last accepted frame bits [381:0]; reset 0.
- `valid` output 1: one-cycle pulse when `data` is updated; reset 0.
- `done` output 1: sticky; set with the first `valid`, cleared only by reset; reset 0.
- `err` output 1: sticky error flag; reset 0; cleared on the first byte of the next frame.

## Operation
- Byte receiver (`uart_rx_byte`):
  - 2-FF synchroniser on `RxD`, reset value 1.
  - IDLE: a falling edge on the synchronised line starts a half-bit wait of `CLOCKS_PER_BAUD/2`.
  - Re-sample: if the line is high, it was a glitch; return to IDLE with no output.
  - Otherwise sample 8 data bits LSB first, one every `CLOCKS_PER_BAUD`, then the stop bit.
  - Stop = 1: pulse `o_wr` for 1 cycle with `o_data`.
  - Stop = 0: pulse `o_ferr` instead, then wait for the line to return high before re-arming.
- Assembler FSM states: IDLE, COLLECT, CHECK.
  - IDLE, on `o_wr`: shift register `sr[383:0] <= {sr[375:0], o_data}`, `count <= 1`, clear `err`, go to COLLECT.
  - COLLECT, on each `o_wr`: shift the byte in and increment `count`. When `count` becomes 48, go to CHECK.
  - CHECK (1 cycle):
    - If `sr[383:382] == 0`: `data <= sr[381:0]`, pulse `valid`, set `done`.
    - Else: set `err`; `data` is unchanged and there is no `valid`.
    - Return to IDLE in both cases.
- Timeout:
  - The counter clears on every `o_wr` and runs only in COLLECT.
  - Reaching `TIMEOUT_BAUDS*CLOCKS_PER_BAUD` discards the partial frame: set `err`, go to IDLE.
  - A 49th stray byte is absorbed as a partial frame and discarded by timeout.
- `o_ferr` in COLLECT: discard the partial frame, set `err`, go to IDLE. In IDLE it is ignored.
- `o_wr` and timeout terminal count in the same cycle: the byte wins; the counter clears.
- `o_wr` cannot arrive during CHECK, because bytes are ≥ 10·`CLOCKS_PER_BAUD` apart.
- Reset assertion at any point immediately forces:
  - all outputs to 0;
  - FSMs to IDLE;
  - `sr` and the counters to 0;
  - the synchroniser to 1.

## Timing
- `o_wr` rises 2 + `CLOCKS_PER_BAUD/2` + 9·`CLOCKS_PER_BAUD` cycles (±1) after the `RxD` falling edge of the start bit.
- `valid` and the new `data` appear exactly 2 cycles after the 48th `o_wr`: one cycle for the shift, one for CHECK.
- `err` is set 1 cycle after its cause: timeout terminal count, `o_ferr`, or CHECK failure.
- Back-to-back frames with zero inter-byte gap are fully supported; minimum frame time is 480·`CLOCKS_PER_BAUD`.

## Structure
- Shared package constants: `FRAME_BYTES = 48`, `PAD_BITS = 2`, `DATA_BITS = 382`, and the assembler state encoding (shared with the transmitter's byte count).
- One sub-module, `uart_rx_byte` (bit-level receiver). Ports:
  - `clk`, `reset`
  - `i_rx`
  - `o_wr`, `o_data[7:0]`, `o_ferr`
- Counters are sized from parameters with `$clog2`.

## Test plan
All scenarios use `CLOCKS_PER_BAUD = 16` and `TIMEOUT_BAUDS = 4`.
- Reset, idle line, 48 bytes 0x00,0x01,…,0x2F → `data == 382'h000102…2F` truncated to 382 bits, one `valid` pulse 2 cycles after last `o_wr`, `done` = 1 thereafter, `err` = 0.
- First byte 0xC1, then 47 bytes 0xFF → no `valid`, `err` = 1, `data` keeps its previous value. A following good frame then clears `err` on its first byte and pulses `valid`.
- 20 bytes, then line idle for 64 cycles → `err` = 1, no `valid`. A full good frame afterwards is received correctly.
- Byte 10 sent with stop bit = 0 → `o_ferr` pulse, frame discarded, `err` = 1. The next 48-byte frame is accepted.
- 1-cycle low glitch on an idle `RxD` → no `o_wr`, FSM stays in IDLE.
- Assert `reset` low mid-frame at byte 30, release, send a full frame → outputs are 0 during reset, and only the post-reset frame appears on `data`.
